// File: rtl/ack_if_arbiter.sv
// ack_if_arbiter
//   Source-domain controller that shares a single ack_if_sync CDC channel
//   between NUM_REQ requesters. A round-robin grant selects one requester,
//   its payload is latched and tagged with the requester ID, a one-cycle
//   valid pulse is launched, and the synced ack pulse is awaited. A timeout
//   and a minimum idle gap keep the pulse synchronizers from overrunning.
//
//   Ports
//     clk, rst      source clock, asynchronous active-high reset
//     req_valid     per-requester data-present flags
//     req_data      packed payloads, requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready     1-cycle pulse: payload of requester i accepted
//     req_done      1-cycle pulse: transfer for requester i acknowledged
//     req_err       1-cycle pulse: transfer for requester i timed out
//     chan_data     {id, payload} to the channel, stable between launches
//     chan_valid    1-cycle launch pulse to the channel
//     chan_ack      1-cycle ack pulse from the channel
//     stray_ack     1-cycle pulse: ack arrived outside WAIT_ACK and was dropped
//     busy          controller is not idle
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | searching for a requester from rr_ptr upward
//   LAUNCH   | drive chan_valid/chan_data, advance rr_ptr, clear timer
//   WAIT_ACK | waiting for chan_ack, counting towards the timeout
//   GAP      | MIN_GAP idle cycles so the pulse synchronizers can settle
module ack_if_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int MIN_GAP    = 2,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [ID_W+DATA_WIDTH-1:0]    chan_data,
    output logic                          chan_valid,
    input  logic                          chan_ack,
    output logic                          stray_ack,
    output logic                          busy
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [DATA_WIDTH-1:0]      pay_q, pay_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [NUM_REQ-1:0]         ready_q, ready_d;
    logic [NUM_REQ-1:0]         done_q, done_d;
    logic [NUM_REQ-1:0]         err_q, err_d;
    logic [ID_W+DATA_WIDTH-1:0] cdata_q, cdata_d;
    logic                       cvalid_q, cvalid_d;
    logic                       stray_q, stray_d;
    logic                       busy_q, busy_d;

    logic                       gnt_found;
    logic [ID_W-1:0]            gnt_id;
    int unsigned                scan_idx;
    logic [NUM_REQ-1:0]         id_oh;

    assign id_oh = NUM_REQ'(1) << id_q;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        pay_d    = pay_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        ready_d  = '0;
        done_d   = '0;
        err_d    = '0;
        cdata_d  = cdata_q;
        cvalid_d = 1'b0;
        stray_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    ready_d = NUM_REQ'(1) << gnt_id;
                    id_d    = gnt_id;
                    pay_d   = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cvalid_d = 1'b1;
                cdata_d  = {id_q, pay_q};
                rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                timer_d  = '0;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Ack wins over the timeout when both land on the terminal cycle.
                if (chan_ack) begin
                    done_d  = id_oh;
                    gap_d   = GAP_LAST;
                    state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    err_d   = id_oh;
                    gap_d   = GAP_LAST;
                    state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
                end else if (TIMEOUT != 0) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acks outside WAIT_ACK are dropped and flagged, never completing anything.
        if (chan_ack && (state_q != ST_WAIT_ACK)) begin
            stray_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            pay_q    <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
            ready_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
            stray_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            pay_q    <= pay_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
            stray_q  <= stray_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready  = ready_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign chan_data  = cdata_q;
    assign chan_valid = cvalid_q;
    assign stray_ack  = stray_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ack_if_arbiter.sv
module tb_ack_if_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready, req_done, req_err;
    logic [9:0]  chan_data;
    logic        chan_valid;
    logic        chan_ack = 1'b0;
    logic        stray_ack, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [9:0] exp_chan[$];
    logic [7:0] exp_end[$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          dly;
        int          exp_id;
        bit          exp_err;
    } vec_t;

    vec_t tbl[9];

    ack_if_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(16), .MIN_GAP(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .chan_data(chan_data), .chan_valid(chan_valid), .chan_ack(chan_ack),
        .stray_ack(stray_ack), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: compares channel launches and completions as they appear.
    always @(negedge clk) begin
        if (!rst) begin
            if (chan_valid) begin
                if (exp_chan.size() == 0) chk("chan_unexpected", exp_chan.size(), 1);
                else chk("chan_data", chan_data, exp_chan.pop_front());
            end
            if (|req_done || |req_err) begin
                if (exp_end.size() == 0) chk("end_unexpected", exp_end.size(), 1);
                else chk("done_err", {req_done, req_err}, exp_end.pop_front());
            end
            if (|{req_ready, req_done, req_err})
                chk("one_hot_pulse", $countones({req_ready, req_done, req_err}), 1);
        end
    end

    task automatic push_exp(input int id, input logic [31:0] d, input bit is_err);
        logic [7:0] oh;
        oh = 8'h01 << id;
        exp_chan.push_back({id[1:0], d[id*8 +: 8]});
        exp_end.push_back(is_err ? {4'h0, oh[3:0]} : {oh[3:0], 4'h0});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 4'b0 && n < 20);
        chk("ready_seen", n < 20, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        chan_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One transfer: dly<0 means never ack, otherwise ack dly cycles after chan_valid.
    task automatic run_xfer(input logic [3:0] v, input logic [31:0] d, input int dly,
                            input int exp_id, input bit exp_err);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << exp_id;
        req_valid = v;
        req_data  = d;
        push_exp(exp_id, d, exp_err);
        wait_ready(n);
        chk("grant", req_ready, oh);
        req_valid = '0;
        @(negedge clk);
        chk("grant_to_valid", chan_valid, 1);
        if (dly < 0) begin
            n = 0;
            while (req_err == 4'b0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", n, 16);
        end else begin
            repeat (dly) @(negedge clk);
            chan_ack = 1'b1;
            @(negedge clk);
            chan_ack = 1'b0;
            chk("ack_to_done", req_done, oh);
        end
        @(negedge clk);
        chk("busy_in_gap", busy, 1);
        @(negedge clk);
        chk("idle_after_gap", busy, 0);
    endtask

    initial begin
        int n;
        int prev_done;
        int id;

        tbl[0] = '{4'b0100, 32'h33A52211,  4, 2, 1'b0};
        tbl[1] = '{4'b1111, 32'h44332211,  0, 3, 1'b0};
        tbl[2] = '{4'b1111, 32'h88776655,  0, 0, 1'b0};
        tbl[3] = '{4'b1111, 32'hDEADBEEF,  0, 1, 1'b0};
        tbl[4] = '{4'b1111, 32'h0F1E2D3C,  0, 2, 1'b0};
        tbl[5] = '{4'b0001, 32'h000000C3, -1, 0, 1'b1};
        tbl[6] = '{4'b0011, 32'h00009A7B, 15, 1, 1'b0};
        tbl[7] = '{4'b1001, 32'h5A00F0A0,  2, 3, 1'b0};
        tbl[8] = '{4'b0110, 32'h00FF0100,  1, 1, 1'b0};

        #1;
        chk("rst_outputs", {req_ready, req_done, req_err, chan_valid, stray_ack, busy}, 0);
        chk("rst_chan_data", chan_data, 0);
        do_reset();

        for (int i = 0; i < 9; i++)
            run_xfer(tbl[i].valid, tbl[i].data, tbl[i].dly, tbl[i].exp_id, tbl[i].exp_err);

        // Held requests with immediate acks: grants rotate 0,1,2,3,0.
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        prev_done = 0;
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            push_exp(id, req_data, 1'b0);
            wait_ready(n);
            chk("rr_grant", req_ready, 4'b0001 << id);
            @(negedge clk);
            if (k > 0) chk("rr_launch_spacing_ge4", (cyc - prev_done) >= 4, 1);
            chan_ack = 1'b1;
            @(negedge clk);
            chan_ack = 1'b0;
            chk("rr_done", req_done, 4'b0001 << id);
            prev_done = cyc;
            if (k == 4) req_valid = '0;
        end
        wait_idle();

        // Stray ack while idle.
        repeat (2) @(negedge clk);
        chan_ack = 1'b1;
        @(negedge clk);
        chan_ack = 1'b0;
        chk("stray_idle", stray_ack, 1);
        chk("stray_idle_no_done", req_done, 0);

        // Ack held two cycles: first completes, second lands in GAP.
        req_valid = 4'b1000;
        req_data  = 32'h7E000000;
        push_exp(3, req_data, 1'b0);
        wait_ready(n);
        chk("stray_grant", req_ready, 4'b1000);
        req_valid = '0;
        @(negedge clk);
        chan_ack = 1'b1;
        @(negedge clk);
        chk("gap_done", req_done, 4'b1000);
        @(negedge clk);
        chan_ack = 1'b0;
        chk("stray_gap", stray_ack, 1);
        chk("stray_gap_no_done", req_done, 0);
        wait_idle();
        run_xfer(4'b0101, 32'h00610042, 3, 0, 1'b0);

        // Reset in WAIT_ACK with rr_ptr at 2.
        req_valid = 4'b0010;
        req_data  = 32'h00006600;
        exp_chan.push_back({2'd1, 8'h66});
        wait_ready(n);
        chk("pre_rst_grant", req_ready, 4'b0010);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {req_ready, req_done, req_err, chan_valid, stray_ack, busy}, 0);
        chk("mid_rst_chan_data", chan_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_valid = 4'b1111;
        req_data  = 32'h99887766;
        push_exp(0, req_data, 1'b0);
        wait_ready(n);
        chk("post_rst_grant", req_ready, 4'b0001);
        req_valid = '0;
        @(negedge clk);
        chan_ack = 1'b1;
        @(negedge clk);
        chan_ack = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_chan.size() + exp_end.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
